hv_distance_classifier: RTL
===========================

HV_DISTANCE_CLASSIFIER -- requirements
Module: hv_distance_classifier

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter DIM, default 8, SHALL set the hypervector dimension in bits.
REQ-003 Parameter PAR_BITS, default 2, SHALL set the bits per chunk; DIM SHALL be an integer multiple of PAR_BITS (NUM_CHUNKS = DIM/PAR_BITS).
REQ-004 Derived widths SHALL be IDX_W = max(1, clog2(NUM_CHUNKS)) and CNT_W = clog2(DIM+1).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 en  input  1  one-cycle strobe: in_bits holds a valid query chunk; driven directly by the upstream bundler's done.
REQ-008 clr  input  1  synchronous abort of any partial query.
REQ-009 in_bits  input  PAR_BITS  query chunk from the upstream bundler's out_bits.
REQ-010 proto_0  input  PAR_BITS  class-0 (non-seizure) prototype chunk at chunk_idx, valid in the same cycle.
REQ-011 proto_1  input  PAR_BITS  class-1 (seizure) prototype chunk at chunk_idx, valid in the same cycle.
REQ-012 chunk_idx  output  IDX_W  index of the next expected chunk; also the prototype memory address.
REQ-013 busy  output  1  high while a query is partially accumulated.
REQ-014 done  output  1  one-cycle pulse: result valid.
REQ-015 pred  output  1  predicted class: 0 = non-seizure, 1 = seizure.
REQ-016 dist_0, dist_1  output  CNT_W each  Hamming distance of the last completed query to proto_0 and proto_1.

Function
REQ-017 The FSM SHALL have states IDLE, ACC and RESULT, with registered accumulators acc0 and acc1 of CNT_W bits each.
REQ-018 On each accepted en, the block SHALL add popcount(in_bits ^ proto_0) to acc0, add popcount(in_bits ^ proto_1) to acc1, and increment chunk_idx.
REQ-019 IDLE + en, not the last chunk: acc SHALL load the chunk count (not add to a stale value), and the FSM SHALL go to ACC.
REQ-020 ACC + en, chunk_idx < NUM_CHUNKS-1: the block SHALL accumulate and remain in ACC.
REQ-021 en with chunk_idx == NUM_CHUNKS-1: the block SHALL accumulate; at that edge dist_0/dist_1 SHALL take the final sums and pred SHALL take (final acc1 < final acc0); chunk_idx SHALL wrap to 0; the FSM SHALL go to RESULT.
REQ-022 Latency: done SHALL be high for exactly the one cycle after the edge that accepts the last chunk.
REQ-023 Ties (acc1 == acc0) SHALL give pred = 0.
REQ-024 RESULT SHALL last one cycle, then return to IDLE unconditionally.
REQ-025 RESULT + en: that chunk SHALL be accepted as chunk 0 of a new query (acc loaded, chunk_idx = 1, next state ACC), so there is no dead cycle.
REQ-026 When NUM_CHUNKS == 1, every en SHALL complete a query; en in RESULT SHALL produce another RESULT cycle.
REQ-027 Cycles without en SHALL leave acc, chunk_idx and the state unchanged; gaps of any length between chunks are legal.
REQ-028 busy SHALL be 1 exactly when the state is ACC.
REQ-029 clr SHALL take priority over en: next state IDLE, acc and chunk_idx cleared, the chunk that cycle discarded, done suppressed.
REQ-030 clr SHALL leave dist_0, dist_1 and pred unchanged.
REQ-031 dist_0, dist_1 and pred SHALL hold their values until the next completed query.
REQ-032 Accumulators SHALL never overflow, since the maximum sum is DIM and fits in CNT_W bits.

Reset
REQ-033 While rst is high: state IDLE; acc0, acc1 and chunk_idx = 0; busy, done, pred = 0; dist_0, dist_1 = 0.
REQ-034 rst asserted mid-query SHALL discard the partial query; the first en after deassertion SHALL be treated as chunk 0.

Verification (DIM=8, PAR_BITS=2, 4 chunks)
V-1 rst pulse mid-simulation -> all outputs 0 immediately, with no clock edge needed.
V-2 4x en, in_bits=00, proto_0=00, proto_1=11 -> done one cycle after the 4th en; dist_0=0, dist_1=8, pred=0; chunk_idx back to 0.
V-3 4x en, in_bits=01, proto_0=00, proto_1=11 -> dist_0=4, dist_1=4, pred=0 (tie).
V-4 en strobes separated by 9 idle cycles, in_bits=11, proto_0=00, proto_1=10 -> chunk_idx and busy hold during gaps; dist_0=8, dist_1=4, pred=1.
V-5 2x en, then clr, then a V-2 query -> no done after clr; busy drops; result identical to V-2; prior dist/pred held until then.
V-6 Back-to-back: en on every cycle for 8 cycles (V-4 data, then V-2 data) -> done in two cycles, with the second query's chunk 0 accepted in the first RESULT cycle; results V-4 then V-2.

Source files
------------

// File: rtl/hv_distance_classifier.sv
// hv_distance_classifier: chunk-serial Hamming-distance classifier of a query hypervector against two class prototypes
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   en, clr              chunk strobe, synchronous abort of a partial query
//   in_bits              query chunk (PAR_BITS)
//   proto_0, proto_1     prototype chunks at chunk_idx (PAR_BITS)
//   chunk_idx            next expected chunk / prototype memory address (IDX_W)
//   busy, done           query partially accumulated, one-cycle result strobe
//   pred                 1 when the query is strictly closer to proto_1
//   dist_0, dist_1       Hamming distances of the last completed query (CNT_W)
module hv_distance_classifier #(
    parameter int DIM      = 8,
    parameter int PAR_BITS = 2,
    localparam int NUM_CHUNKS = DIM / PAR_BITS,
    localparam int IDX_W      = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1,
    localparam int CNT_W      = $clog2(DIM + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic [PAR_BITS-1:0] in_bits,
    input  logic [PAR_BITS-1:0] proto_0,
    input  logic [PAR_BITS-1:0] proto_1,
    output logic [IDX_W-1:0]    chunk_idx,
    output logic                busy,
    output logic                done,
    output logic                pred,
    output logic [CNT_W-1:0]    dist_0,
    output logic [CNT_W-1:0]    dist_1
);
    typedef enum logic [1:0] {IDLE, ACC, RESULT} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CHUNKS - 1);
    state_t state;
    logic [CNT_W-1:0] acc0, acc1, sum0, sum1;
    logic last;
    function automatic logic [CNT_W-1:0] popcnt(input logic [PAR_BITS-1:0] v);
        logic [CNT_W-1:0] p;
        p = '0;
        for (int i = 0; i < PAR_BITS; i++) p = p + CNT_W'(v[i]);
        return p;
    endfunction
    // Outside ACC the accumulators are ignored so a new query always starts from zero
    always_comb begin
        last = chunk_idx == LAST;
        sum0 = (state == ACC ? acc0 : '0) + popcnt(in_bits ^ proto_0);
        sum1 = (state == ACC ? acc1 : '0) + popcnt(in_bits ^ proto_1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc0      <= '0;
            acc1      <= '0;
            chunk_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pred      <= 1'b0;
            dist_0    <= '0;
            dist_1    <= '0;
        end else if (clr) begin
            state     <= IDLE;
            acc0      <= '0;
            acc1      <= '0;
            chunk_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (en && last) begin
            state     <= RESULT;
            acc0      <= '0;
            acc1      <= '0;
            chunk_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            dist_0    <= sum0;
            dist_1    <= sum1;
            pred      <= sum1 < sum0;
        end else if (en) begin
            state     <= ACC;
            acc0      <= sum0;
            acc1      <= sum1;
            chunk_idx <= chunk_idx + IDX_W'(1);
            busy      <= 1'b1;
            done      <= 1'b0;
        end else if (state == RESULT) begin
            state <= IDLE;
            done  <= 1'b0;
        end
    end
endmodule
